alu_seq: RTL and testbench

- Parametrised WIDTH-bit ALU, successor to the 1-bit ALU slice.
- Adds a registered result, valid/ready handshakes on input and output, and Zero/Carry/Overflow flags.
- Adds an iterative shift-add multiply that takes WIDTH cycles.
- Sits between the register-file read stage and the write-back stage of the 16-bit CPU datapath.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_comb.sv | 44 ++++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU (alu_seq).
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_NOR = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational WIDTH-bit logic/add/sub/set-less-than unit with carry and signed overflow.
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic             sub_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             add_ovf_s;

    // Shared adder; SLT reuses the subtract path and corrects the sign with overflow
    always_comb begin
        sub_s     = (op == OP_SUB) || (op == OP_SLT);
        b_eff_s   = sub_s ? ~b : b;
        sum_s     = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
        add_ovf_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        result    = {WIDTH{1'b0}};
        carry     = 1'b0;
        overflow  = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_NOR: result = ~(a | b);
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD, OP_SUB: begin
                result   = sum_s[WIDTH-1:0];
                carry    = sum_s[WIDTH];
                overflow = add_ovf_s;
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes, registered result/flags and
// an iterative shift-add multiplier present only when ALU_SEQ_MUL_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
);

    state_t           state_r, state_nx;
    logic             in_ready_r, in_ready_nx;
    logic             out_valid_r, out_valid_nx;
    logic [WIDTH-1:0] result_r, result_nx;
    logic             zero_r, zero_nx, carry_r, carry_nx, ovf_r, ovf_nx;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s, alu_ovf_s;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;
    logic [2*WIDTH-1:0] acc_r, acc_nx, mcand_r, mcand_nx, acc_add_s;
    logic [WIDTH-1:0]   mplier_r, mplier_nx;
    logic [CNT_W-1:0]   cnt_r, cnt_nx;
`endif

    alu_comb #(.WIDTH(WIDTH)) u_alu (
        .a        (A),
        .b        (B),
        .op       (Operation),
        .result   (alu_res_s),
        .carry    (alu_carry_s),
        .overflow (alu_ovf_s)
    );

    // Next-state, handshake and datapath updates
    always_comb begin
        state_nx     = state_r;
        out_valid_nx = out_valid_r;
        result_nx    = result_r;
        zero_nx      = zero_r;
        carry_nx     = carry_r;
        ovf_nx       = ovf_r;
`ifdef ALU_SEQ_MUL_EN
        acc_nx    = acc_r;
        mcand_nx  = mcand_r;
        mplier_nx = mplier_r;
        cnt_nx    = cnt_r;
        acc_add_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
`endif
        case (state_r)
            ST_IDLE: begin
                if (InValid && in_ready_r) begin
                    if (Operation == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
                        // The accept edge performs step 0 so OutValid lands WIDTH cycles later
                        state_nx  = ST_MUL_RUN;
                        acc_nx    = B[0] ? {{WIDTH{1'b0}}, A} : {(2*WIDTH){1'b0}};
                        mcand_nx  = {{(WIDTH-1){1'b0}}, A, 1'b0};
                        mplier_nx = {1'b0, B[WIDTH-1:1]};
                        cnt_nx    = CNT_W'(1);
`else
                        state_nx     = ST_DONE;
                        out_valid_nx = 1'b1;
                        result_nx    = {WIDTH{1'b0}};
                        zero_nx      = 1'b1;
                        carry_nx     = 1'b0;
                        ovf_nx       = 1'b1;
`endif
                    end else begin
                        state_nx     = ST_DONE;
                        out_valid_nx = 1'b1;
                        result_nx    = alu_res_s;
                        zero_nx      = (alu_res_s == {WIDTH{1'b0}});
                        carry_nx     = alu_carry_s;
                        ovf_nx       = alu_ovf_s;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL_RUN: begin
                acc_nx    = acc_add_s;
                mcand_nx  = mcand_r << 1;
                mplier_nx = mplier_r >> 1;
                cnt_nx    = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_nx     = ST_DONE;
                    out_valid_nx = 1'b1;
                    result_nx    = acc_add_s[WIDTH-1:0];
                    zero_nx      = (acc_add_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    carry_nx     = 1'b0;
                    ovf_nx       = |acc_add_s[2*WIDTH-1:WIDTH];
                end else begin
                    state_nx = ST_MUL_RUN;
                end
            end
`endif
            ST_DONE: begin
                if (OutReady) begin
                    state_nx     = ST_IDLE;
                    out_valid_nx = 1'b0;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx     = ST_IDLE;
                out_valid_nx = 1'b0;
            end
        endcase
        in_ready_nx = (state_nx == ST_IDLE);
    end

    // State, handshake, output and multiplier registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r     <= state_nx;
            in_ready_r  <= in_ready_nx;
            out_valid_r <= out_valid_nx;
            result_r    <= result_nx;
            zero_r      <= zero_nx;
            carry_r     <= carry_nx;
            ovf_r       <= ovf_nx;
`ifdef ALU_SEQ_MUL_EN
            acc_r    <= acc_nx;
            mcand_r  <= mcand_nx;
            mplier_r <= mplier_nx;
            cnt_r    <= cnt_nx;
`endif
        end
    end

    assign InReady  = in_ready_r;
    assign OutValid = out_valid_r;
    assign Result   = result_r;
    assign Zero     = zero_r;
    assign Carry    = carry_r;
    assign Overflow = ovf_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

    logic        Clock = 1'b0;
    logic        Reset, InValid, InReady, OutValid, OutReady;
    logic [15:0] A, B, Result;
    logic [2:0]  Operation;
    logic        Zero, Carry, Overflow;

`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_LAT = 16;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [2:0]  zcv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    alu_seq #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Operation(Operation), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Zero(Zero), .Carry(Carry), .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares the head expectation on every valid cycle, pops on handshake
    always @(negedge Clock) begin
        if (Reset) begin
            prev_valid = 1'b0;
        end else begin
            if (OutValid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    cur = exp_q[0];
                    if (!prev_valid)
                        chk({cur.name, "_latency"}, cyc - cur.acc + 1, cur.lat);
                    chk({cur.name, "_result"}, {16'd0, Result}, {16'd0, cur.res});
                    chk({cur.name, "_zcv"}, {29'd0, Zero, Carry, Overflow}, {29'd0, cur.zcv});
                    if (OutReady) void'(exp_q.pop_front());
                end
            end
            prev_valid = OutValid;
        end
    end

    // Called at posedge+#1; waits for InReady, presents one op, records expectation
    task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] res, input logic [2:0] zcv,
                         input int lat);
        exp_t e;
        int waited;
        waited = 0;
        while (!InReady && waited < 100) begin
            @(posedge Clock); #1;
            waited++;
        end
        if (!InReady) begin
            chk({name, "_inready_timeout"}, 32'd0, 32'd1);
        end else begin
            A = a; B = b; Operation = op; InValid = 1'b1;
            @(posedge Clock); #1;
            e.name = name; e.res = res; e.zcv = zcv; e.lat = lat; e.acc = cyc;
            exp_q.push_back(e);
            InValid = 1'b0;
            A = ~a;
            B = a ^ b;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge Clock); #1;
            waited++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        A = 16'h0000; B = 16'h0000; Operation = 3'b000;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_outputs", {12'd0, OutValid, Zero, Carry, Overflow, Result}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("inready_after_reset", {31'd0, InReady}, 32'd1);

        // Directed vectors: name, A, B, op, Result, {Zero,Carry,Overflow}, latency
        issue("add_wrap",   16'hFFFF, 16'h0001, 3'b100, 16'h0000, 3'b110, 1);
        issue("add_ovf",    16'h7FFF, 16'h0001, 3'b100, 16'h8000, 3'b001, 1);
        issue("sub_ovf",    16'h8000, 16'h0001, 3'b101, 16'h7FFF, 3'b011, 1);
        issue("sub_zero",   16'h0005, 16'h0005, 3'b101, 16'h0000, 3'b110, 1);
        issue("sub_borrow", 16'h0000, 16'h0001, 3'b101, 16'hFFFF, 3'b000, 1);
        issue("slt_neg",    16'hFFFF, 16'h0001, 3'b110, 16'h0001, 3'b000, 1);
        issue("slt_false",  16'h0001, 16'hFFFF, 3'b110, 16'h0000, 3'b100, 1);
        issue("slt_min",    16'h8000, 16'h7FFF, 3'b110, 16'h0001, 3'b000, 1);
        issue("nor",        16'h0F0F, 16'h00FF, 3'b001, 16'hF000, 3'b000, 1);
        issue("or",         16'h0F0F, 16'h00FF, 3'b010, 16'h0FFF, 3'b000, 1);
`ifdef ALU_SEQ_MUL_EN
        issue("mul_small",  16'h0012, 16'h0034, 3'b111, 16'h03A8, 3'b000, MUL_LAT);
        issue("mul_hi",     16'h0100, 16'h0100, 3'b111, 16'h0000, 3'b101, MUL_LAT);
        issue("mul_max",    16'hFFFF, 16'hFFFF, 3'b111, 16'h0001, 3'b001, MUL_LAT);
`else
        issue("mul_unsup",  16'h0003, 16'h0004, 3'b111, 16'h0000, 3'b101, MUL_LAT);
        issue("mul_unsup2", 16'h0012, 16'h0034, 3'b111, 16'h0000, 3'b101, MUL_LAT);
`endif
        drain();

        // Backpressure: result held, InReady low, extra requests ignored
        OutReady = 1'b0;
        issue("and_bp", 16'h0F0F, 16'h00FF, 3'b000, 16'h000F, 3'b000, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_inready_low", {31'd0, InReady}, 32'd0);
            InValid = 1'b1; Operation = 3'b010; A = 16'hFFFF; B = 16'h0000;
            @(posedge Clock); #1;
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock); #1;
        chk("bp_release_idle", {30'd0, OutValid, InReady}, 32'd1);
        drain();

        // Reset during a multiply aborts it without an OutValid pulse
        issue("mul_abort", 16'h0012, 16'h0034, 3'b111,
`ifdef ALU_SEQ_MUL_EN
              16'h03A8, 3'b000,
`else
              16'h0000, 3'b101,
`endif
              MUL_LAT);
        repeat (4) begin
            @(posedge Clock); #1;
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        exp_q.delete();
        chk("abort_outputs", {12'd0, OutValid, Zero, Carry, Overflow, Result}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("abort_inready", {31'd0, InReady}, 32'd1);
        issue("xor_after_abort", 16'hAAAA, 16'h5555, 3'b011, 16'hFFFF, 3'b000, 1);
        drain();
        repeat (20) @(posedge Clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
